fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of decode and the control unit. It owns the program counter, issues word reads to instruction memory, and presents each fetched instruction with its PC to decode through a valid/ready handshake. It absorbs decode stalls with a one-entry skid buffer and applies taken-branch redirects (`pc_src` plus `pc_target` from decode/execute) by flushing wrong-path instructions.

---
 rtl/rv_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 64 ++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core types: data width, NOP encoding, and fetch-stage state and entry types.
// FETCH_MISALIGN_CHECK_EN adds the FAULT state.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        FAULT = 2'd3
`endif
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, fetch->decode handshake and redirect inputs.
interface fetch_stage_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic            id_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault,
        input  imem_rdata, id_ready, pc_src, pc_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault,
        output imem_rdata, id_ready, pc_src, pc_target
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Output slot plus one-entry skid slot between instruction memory and decode.
// A response is shown directly when the output slot is empty, so it is visible in its arrival cycle.
module fetch_skid_buffer
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  fetch_entry_t rsp,
    input  logic         out_ready,
    output fetch_entry_t head,
    output logic         accept,
    output logic         skid_fill,
    output logic         skid_full
);

    localparam fetch_entry_t EmptyEntry = '{valid: 1'b0, instr: NOP_INSTR, pc: RESET_PC};

    fetch_entry_t out_q, out_d;
    fetch_entry_t skid_q, skid_d;

    always_comb begin
        head      = (!out_q.valid && rsp.valid) ? rsp : out_q;
        accept    = head.valid && out_ready;
        // A held output plus a landing response is the only way the skid slot fills
        skid_fill = out_q.valid && !accept && rsp.valid;
        skid_full = skid_q.valid;
        out_d     = out_q;
        skid_d    = skid_q;
        if (flush) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_q.valid) begin
            if (accept) begin
                if (skid_q.valid) begin
                    out_d        = skid_q;
                    skid_d.valid = 1'b0;
                    if (rsp.valid) skid_d = rsp;
                end else if (rsp.valid) begin
                    out_d = rsp;
                end else begin
                    out_d.valid = 1'b0;
                end
            end else if (rsp.valid) begin
                skid_d = rsp;
            end
        end else if (rsp.valid && !accept) begin
            out_d = rsp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= EmptyEntry;
            skid_q <= EmptyEntry;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request issue, redirect flush and decode handshake.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_pc_q;

    logic [XLEN-1:0] target;
    logic            issue;
    logic            skid_fill;
    logic            skid_full;
    logic            accept;
    fetch_entry_t    rsp;
    fetch_entry_t    head;

    assign target = {bus.pc_target[XLEN-1:2], 2'b00};
    // Stop issuing as soon as the skid slot fills; the next response would have nowhere to go
    assign issue  = (state_q == RUN) && !bus.pc_src && !skid_fill;
    assign rsp    = '{valid: pend_valid_q, instr: bus.imem_rdata, pc: pend_pc_q};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;
    logic fault_q;
    assign misalign        = |bus.pc_target[1:0];
    assign bus.fetch_fault = fault_q;
`else
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^bus.pc_target[1:0];
    assign bus.fetch_fault = 1'b0;
`endif

    fetch_skid_buffer #(
        .RESET_PC(RESET_PC)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.pc_src),
        .rsp      (rsp),
        .out_ready(bus.id_ready),
        .head     (head),
        .accept   (accept),
        .skid_fill(skid_fill),
        .skid_full(skid_full)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = head.valid;
    assign bus.if_instr    = head.valid ? head.instr : NOP_INSTR;
    assign bus.if_pc       = head.pc;
    assign bus.if_pc_plus4 = head.pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            // A redirect never issues, so this also discards any in-flight response
            pend_valid_q <= issue;
            if (issue) pend_pc_q <= pc_q;
            if (bus.pc_src) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if ((state_q == FAULT) || misalign) begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end else begin
                    state_q <= RUN;
                    pc_q    <= target;
                end
`else
                state_q <= RUN;
                pc_q    <= target;
`endif
            end else begin
                if (issue) pc_q <= pc_q + XLEN'(4);
                case (state_q)
                    RESET: state_q <= RUN;
                    RUN:   if (skid_fill) state_q <= HOLD;
                    HOLD:  if (accept && skid_full) state_q <= RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
                    FAULT: state_q <= FAULT;
`endif
                    default: state_q <= RESET;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus random handshake/redirect traffic,
// scored against a program-order model of fetched words.
module tb_fetch_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    logic [31:0] exp_fetch;
    logic        last_req;
    logic [31:0] last_addr;
    int          idle;
    bit          fault_mode;

    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_pc, s_instr, s_plus4;
    logic [31:0] p;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_fetch  = 32'h0;
        last_req   = 1'b0;
        last_addr  = 32'h0;
        idle       = 0;
        fault_mode = 1'b0;
    endtask

    // Scoreboard at the negedge: outputs are settled for this cycle's inputs
    task automatic observe();
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        s_pc    = bus.if_pc;
        s_instr = bus.if_instr;
        s_plus4 = bus.if_pc_plus4;
        s_fault = bus.fetch_fault;

        chk("pc_plus4", s_plus4, s_pc + 32'd4);
        if (!s_valid) chk("nop_when_invalid", s_instr, NOP_INSTR);
        chk("valid_vs_model", s_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("pc_order", s_pc, q[0]);
            chk("instr_data", s_instr, mem_word(q[0]));
        end
        if (s_req) begin
            chk("fetch_addr", s_addr, exp_fetch);
            chk("addr_align", s_addr[1:0], 2'b00);
        end
        if (bus.pc_src) chk("no_req_on_redirect", s_req, 1'b0);

        if (s_valid && bus.id_ready && q.size() > 0) void'(q.pop_front());
        if (bus.pc_src) begin
            q.delete();
            exp_fetch = {bus.pc_target[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
            if (bus.pc_target[1:0] != 2'b00) fault_mode = 1'b1;
`endif
        end else if (s_req) begin
            q.push_back(s_addr);
            exp_fetch = s_addr + 32'd4;
        end
        chk("depth_le_2", q.size() <= 2, 1'b1);

        if (bus.pc_src || s_valid) idle = 0;
        else idle++;
        if (!fault_mode) chk("liveness", idle <= 2, 1'b1);

        last_req  = s_req;
        last_addr = s_addr;
    endtask

    task automatic step(input logic rdy, input logic src, input logic [31:0] tgt);
        bus.id_ready  = rdy;
        bus.pc_src    = src;
        bus.pc_target = tgt;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        bus.imem_rdata = last_req ? mem_word(last_addr) : $urandom;
    endtask

    initial begin
        bus.id_ready   = 1'b1;
        bus.pc_src     = 1'b0;
        bus.pc_target  = 32'h0;
        bus.imem_rdata = 32'h0;
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", bus.if_valid, 1'b0);
        chk("rst_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_pc_plus4", bus.if_pc_plus4, 32'h4);
        chk("rst_fault", bus.fetch_fault, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Start-up: requests in cycles 1..3, valid from cycle 2
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (c == 0) chk("startup_no_req", s_req, 1'b0);
            if (c >= 1 && c <= 3) begin
                chk("startup_req", s_req, 1'b1);
                chk("startup_addr", s_addr, 32'(4 * (c - 1)));
            end
            if (c >= 2) begin
                chk("startup_valid", s_valid, 1'b1);
                chk("startup_pc", s_pc, 32'(4 * (c - 2)));
            end
        end

        // Decode stall for three cycles
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        p = s_pc;
        chk("stall_valid", s_valid, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("hold_no_req", s_req, 1'b0);
            chk("stall_pc_stable", s_pc, p);
        end
        step(1'b1, 1'b0, 32'h0);
        chk("release_pc", s_pc, p);
        step(1'b1, 1'b0, 32'h0);
        chk("release_next_pc", s_pc, p + 32'd4);
        step(1'b1, 1'b0, 32'h0);

        // Redirect with a response in flight
        step(1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0);
        chk("redir_bubble", s_valid, 1'b0);
        chk("redir_req", s_req, 1'b1);
        chk("redir_addr", s_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0);
        chk("redir_valid", s_valid, 1'b1);
        chk("redir_pc", s_pc, 32'h0000_0100);

        // Redirect while stalled with the skid full
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_bubble", s_valid, 1'b0);
        chk("flush_addr", s_addr, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_pc", s_pc, 32'h0000_0200);

        // PC wrap
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", s_addr, 32'h0);
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", s_plus4, 32'h0);

        // Random handshake and redirect traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 6, $urandom & 32'hFFFF_FFFC);
        end

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", bus.imem_req, 1'b0);
        chk("async_rst_valid", bus.if_valid, 1'b0);
        chk("async_rst_pc", bus.if_pc, 32'h0);
        chk("async_rst_addr", bus.imem_addr, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        chk("rerst_no_req", s_req, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        chk("rerst_addr", s_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("rerst_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0);

        // Misaligned redirect target
        step(1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("fault_set", s_fault, 1'b1);
            chk("fault_no_req", s_req, 1'b0);
            chk("fault_no_valid", s_valid, 1'b0);
        end
`else
        step(1'b1, 1'b0, 32'h0);
        chk("misalign_addr", s_addr, 32'h0000_0100);
        chk("misalign_no_fault", s_fault, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        chk("misalign_pc", s_pc, 32'h0000_0100);
`endif
        rst_n = 1'b0;
        #1;
        chk("final_rst_fault", bus.fetch_fault, 1'b0);
        chk("final_rst_req", bus.imem_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
